board_mem_arbiter: RTL

- Shares the single-port 64x2-bit Othello board RAM between two requesters:
  - the VGA cell renderer (hard real-time reads during active video);
  - the game-logic engine (reads and writes of board cells).
- Sits between the H/V sync timing chain and the board storage.
- Video reads have absolute priority and fixed latency.
- Game accesses go through a one-deep valid/ready buffer. Game writes are optionally deferred to vertical blanking, so a frame never shows a half-updated board.

---
 rtl/board_mem_arbiter_pkg.sv | 25 ++
 rtl/board_mem_arbiter_wr_lock.sv | 32 +++
 rtl/board_mem_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/board_mem_arbiter_pkg.sv
// Shared definitions for the Othello board RAM arbiter: cell codes, read-return
// tags and board geometry.
package board_mem_arbiter_pkg;

  localparam int BOARD_N = 8;
  localparam int ADDR_W  = $clog2(BOARD_N * BOARD_N);
  localparam int CELL_W  = 2;

  localparam logic [CELL_W-1:0] CELL_EMPTY = 2'd0;
  localparam logic [CELL_W-1:0] CELL_BLACK = 2'd1;
  localparam logic [CELL_W-1:0] CELL_WHITE = 2'd2;
  localparam logic [CELL_W-1:0] CELL_HINT  = 2'd3;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VID  = 2'd1,
    TAG_GAME = 2'd2
  } tag_t;

  typedef enum logic {
    LOCK_OPEN   = 1'b0,
    LOCK_LOCKED = 1'b1
  } lock_state_t;

endpackage

// File: rtl/board_mem_arbiter_wr_lock.sv
// Write-lock FSM: closes the game write path while the visible lines are drawn
// and reopens it once vertical blanking is sampled.
module board_wr_lock
  import board_mem_arbiter_pkg::*;
#(
  parameter bit ENABLE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic v_active,
  output logic wr_open
);

  lock_state_t state, state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOCK_OPEN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOCK_OPEN:   if (ENABLE && v_active) state_nxt = LOCK_LOCKED;
      LOCK_LOCKED: if (!v_active)          state_nxt = LOCK_OPEN;
      default:     state_nxt = LOCK_OPEN;
    endcase
  end

  assign wr_open = (state == LOCK_OPEN);

endmodule

// File: rtl/board_mem_arbiter.sv
// Single-port board RAM arbiter: video reads take every slot they ask for with
// fixed latency; game ops use a one-deep buffer and fill the remaining slots.
module board_mem_arbiter
  import board_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W            = board_mem_arbiter_pkg::ADDR_W,
  parameter int DATA_W            = board_mem_arbiter_pkg::CELL_W,
  parameter int WR_IN_VBLANK_ONLY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              v_active,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              g_valid,
  output logic              g_ready,
  input  logic              g_we,
  input  logic [ADDR_W-1:0] g_addr,
  input  logic [DATA_W-1:0] g_wdata,
  output logic              g_rvalid,
  output logic [DATA_W-1:0] g_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              pend_valid;
  logic              pend_we;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_wdata;
  logic              wr_open;
  logic              issue_vid, issue_grd, issue_gwr;
  tag_t              tag_p0, tag_p1;

  board_wr_lock #(
    .ENABLE (WR_IN_VBLANK_ONLY != 0)
  ) u_wr_lock (
    .clk      (clk),
    .rst_n    (rst_n),
    .v_active (v_active),
    .wr_open  (wr_open)
  );

  // Only one op can win a slot; a pending write never shadows a pending read
  // because the buffer holds a single request.
  always_comb begin
    issue_vid = vid_req;
    issue_grd = !vid_req && pend_valid && !pend_we;
    issue_gwr = !vid_req && pend_valid && pend_we && wr_open;
  end

  assign g_ready = ~pend_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_we    <= 1'b0;
      pend_addr  <= '0;
      pend_wdata <= '0;
    end else if (issue_grd || issue_gwr) begin
      pend_valid <= 1'b0;
    end else if (g_valid && g_ready) begin
      pend_valid <= 1'b1;
      pend_we    <= g_we;
      pend_addr  <= g_addr;
      pend_wdata <= g_wdata;
    end
  end

  // Stage p0: RAM command register plus the tag naming who gets the read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      tag_p0    <= TAG_NONE;
    end else begin
      mem_en    <= issue_vid || issue_grd || issue_gwr;
      mem_we    <= issue_gwr;
      mem_addr  <= issue_vid ? vid_addr : pend_addr;
      mem_wdata <= pend_wdata;
      tag_p0    <= issue_vid ? TAG_VID : (issue_grd ? TAG_GAME : TAG_NONE);
    end
  end

  // Stage p1: tag aligned with mem_rdata coming back from the RAM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tag_p1 <= TAG_NONE;
    else        tag_p1 <= tag_p0;
  end

  // Stage p2: route the returned cell to its requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid_rvalid <= 1'b0;
      vid_rdata  <= '0;
      g_rvalid   <= 1'b0;
      g_rdata    <= '0;
    end else begin
      vid_rvalid <= (tag_p1 == TAG_VID);
      g_rvalid   <= (tag_p1 == TAG_GAME);
      if (tag_p1 == TAG_VID)  vid_rdata <= mem_rdata;
      if (tag_p1 == TAG_GAME) g_rdata   <= mem_rdata;
    end
  end

endmodule
